// File: rtl/dmem_arbiter.sv
// Purpose: shares one data-memory port between load issue and retired stores, one access in flight.
// Latency: an access accepted in cycle T completes (ld_resp_valid / st_done) in cycle T+MEM_LATENCY.
// Backpressure: ld_req_ready / st_req_ready are combinational grants; requesters hold valid until granted.
//
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   flush                   mispredict squash: blocks load grants, kills the pending load result
//   ld_req_*                load request (addr, size, unsigned, ROB tag) with ready
//   st_req_*                retired store request (addr, size, data) with ready
//   arb2Dmem_*              memory command/addr/size/data, driven only in the accept cycle
//   Dmem2arb_data           memory read data, valid MEM_LATENCY cycles after BUS_LOAD
//   ld_resp_*               extended load data and echoed tag, single-cycle pulse
//   st_done                 store completion pulse
//   busy                    an access is outstanding
module dmem_arbiter #(
    parameter int MEM_LATENCY = 2,
    parameter int ROB_IDX_W   = 5,
    localparam int XLEN       = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 ld_req_valid,
    input  logic [XLEN-1:0]      ld_req_addr,
    input  logic [1:0]           ld_req_size,
    input  logic                 ld_req_unsigned,
    input  logic [ROB_IDX_W-1:0] ld_req_tag,
    output logic                 ld_req_ready,
    input  logic                 st_req_valid,
    input  logic [XLEN-1:0]      st_req_addr,
    input  logic [1:0]           st_req_size,
    input  logic [XLEN-1:0]      st_req_data,
    output logic                 st_req_ready,
    output logic [1:0]           arb2Dmem_command,
    output logic [XLEN-1:0]      arb2Dmem_addr,
    output logic [1:0]           arb2Dmem_size,
    output logic [XLEN-1:0]      arb2Dmem_data,
    input  logic [XLEN-1:0]      Dmem2arb_data,
    output logic                 ld_resp_valid,
    output logic [XLEN-1:0]      ld_resp_data,
    output logic [ROB_IDX_W-1:0] ld_resp_tag,
    output logic                 st_done,
    output logic                 busy
);

    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;

    localparam logic GRANT_LOAD  = 1'b0;
    localparam logic GRANT_STORE = 1'b1;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY);

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_e;

    state_e                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   pend_is_load_q, pend_is_load_d;
    logic                   pend_squashed_q, pend_squashed_d;
    logic [1:0]             size_q, size_d;
    logic                   unsigned_q, unsigned_d;
    logic [ROB_IDX_W-1:0]   tag_q, tag_d;
    logic                   last_grant_q, last_grant_d;

    logic                   resp_cycle;
    logic                   can_accept;
    logic                   ld_cand;
    logic                   grant_ld;
    logic                   grant_st;
    logic [XLEN-1:0]        ext_data;

    // Arbitration and bus drive. A flushed load is simply not a candidate,
    // so a concurrent store wins outright rather than by round-robin.
    always_comb begin
        resp_cycle = (state_q == S_BUSY) && (cnt_q == 4'd1);
        can_accept = !reset && ((state_q == S_IDLE) || resp_cycle);
        ld_cand    = ld_req_valid && !flush;
        grant_ld   = can_accept && ld_cand &&
                     (!st_req_valid || (last_grant_q == GRANT_STORE));
        grant_st   = can_accept && st_req_valid &&
                     (!ld_cand || (last_grant_q == GRANT_LOAD));

        ld_req_ready     = grant_ld;
        st_req_ready     = grant_st;
        arb2Dmem_command = BUS_NONE;
        arb2Dmem_addr    = '0;
        arb2Dmem_size    = '0;
        arb2Dmem_data    = '0;
        if (grant_ld) begin
            arb2Dmem_command = BUS_LOAD;
            arb2Dmem_addr    = ld_req_addr;
            arb2Dmem_size    = ld_req_size;
        end else if (grant_st) begin
            arb2Dmem_command = BUS_STORE;
            arb2Dmem_addr    = st_req_addr;
            arb2Dmem_size    = st_req_size;
            arb2Dmem_data    = st_req_data;
        end
    end

    // Load data extension from the low lanes of the returned word.
    always_comb begin
        ext_data = Dmem2arb_data;
        case (size_q)
            SIZE_BYTE: ext_data = {{(XLEN-8){!unsigned_q && Dmem2arb_data[7]}},
                                   Dmem2arb_data[7:0]};
            SIZE_HALF: ext_data = {{(XLEN-16){!unsigned_q && Dmem2arb_data[15]}},
                                   Dmem2arb_data[15:0]};
            default:   ext_data = Dmem2arb_data;
        endcase
    end

    // Responses. A flush in the response cycle itself has not yet reached
    // pend_squashed_q, so it is checked directly here.
    always_comb begin
        ld_resp_valid = resp_cycle && pend_is_load_q && !pend_squashed_q &&
                        !flush && !reset;
        ld_resp_data  = ld_resp_valid ? ext_data : '0;
        ld_resp_tag   = ld_resp_valid ? tag_q : '0;
        st_done       = resp_cycle && !pend_is_load_q && !reset;
        busy          = (state_q == S_BUSY);
    end

    // Next state. An accept in the response cycle overrides the return to IDLE.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        pend_is_load_d  = pend_is_load_q;
        pend_squashed_d = pend_squashed_q;
        size_d          = size_q;
        unsigned_d      = unsigned_q;
        tag_d           = tag_q;
        last_grant_d    = last_grant_q;

        if (state_q == S_BUSY) begin
            if (cnt_q == 4'd1) begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
            if (flush && pend_is_load_q) begin
                pend_squashed_d = 1'b1;
            end
        end

        if (grant_ld || grant_st) begin
            state_d         = S_BUSY;
            cnt_d           = CNT_INIT;
            pend_is_load_d  = grant_ld;
            pend_squashed_d = 1'b0;
            size_d          = grant_ld ? ld_req_size : st_req_size;
            unsigned_d      = grant_ld ? ld_req_unsigned : 1'b0;
            tag_d           = grant_ld ? ld_req_tag : '0;
            last_grant_d    = grant_ld ? GRANT_LOAD : GRANT_STORE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= S_IDLE;
            cnt_q           <= 4'd0;
            pend_is_load_q  <= 1'b0;
            pend_squashed_q <= 1'b0;
            size_q          <= 2'd0;
            unsigned_q      <= 1'b0;
            tag_q           <= '0;
            last_grant_q    <= GRANT_LOAD;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            pend_is_load_q  <= pend_is_load_d;
            pend_squashed_q <= pend_squashed_d;
            size_q          <= size_d;
            unsigned_q      <= unsigned_d;
            tag_q           <= tag_d;
            last_grant_q    <= last_grant_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Purpose: scoreboard bench for dmem_arbiter at MEM_LATENCY 1, 2 and 3 (one instance each, muxed by sel).
// Latency: expected responses are queued at accept time and due accept cycle + latency.
// Backpressure: load/store drivers hold valid and payload until the selected instance grants.
module tb_dmem_arbiter;

    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [4:0]  tag;
        logic [31:0] data;
        int          acc;
        bit          squash;
    } ld_item_t;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] data;
        int          acc;
    } st_item_t;

    typedef struct {
        bit          is_load;
        logic [31:0] data;
        logic [4:0]  tag;
        int          cyc;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic        ld_req_valid;
    logic [31:0] ld_req_addr;
    logic [1:0]  ld_req_size;
    logic        ld_req_unsigned;
    logic [4:0]  ld_req_tag;
    logic        st_req_valid;
    logic [31:0] st_req_addr;
    logic [1:0]  st_req_size;
    logic [31:0] st_req_data;
    logic [31:0] Dmem2arb_data;

    logic [2:0]       ld_rdy_a, st_rdy_a, ld_vld_a, st_done_a, busy_a;
    logic [2:0][1:0]  cmd_a, size_a;
    logic [2:0][31:0] addr_a, wdata_a, rdata_a;
    logic [2:0][4:0]  tag_a;

    logic [1:0]  sel;
    int          lat;
    int          cyc = 0;
    int          base;
    int          n_cmp;
    int          n_err;

    logic [31:0] mem [256];
    logic [31:0] rdbuf [16];

    ld_item_t ld_q[$];
    st_item_t st_q[$];
    exp_t     sb[$];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_arbiter #(.MEM_LATENCY(g + 1), .ROB_IDX_W(5)) u_dut (
            .clock            (clock),
            .reset            (reset),
            .flush            (flush),
            .ld_req_valid     (ld_req_valid),
            .ld_req_addr      (ld_req_addr),
            .ld_req_size      (ld_req_size),
            .ld_req_unsigned  (ld_req_unsigned),
            .ld_req_tag       (ld_req_tag),
            .ld_req_ready     (ld_rdy_a[g]),
            .st_req_valid     (st_req_valid),
            .st_req_addr      (st_req_addr),
            .st_req_size      (st_req_size),
            .st_req_data      (st_req_data),
            .st_req_ready     (st_rdy_a[g]),
            .arb2Dmem_command (cmd_a[g]),
            .arb2Dmem_addr    (addr_a[g]),
            .arb2Dmem_size    (size_a[g]),
            .arb2Dmem_data    (wdata_a[g]),
            .Dmem2arb_data    (Dmem2arb_data),
            .ld_resp_valid    (ld_vld_a[g]),
            .ld_resp_data     (rdata_a[g]),
            .ld_resp_tag      (tag_a[g]),
            .st_done          (st_done_a[g]),
            .busy             (busy_a[g])
        );
    end

    wire        m_ld_rdy  = ld_rdy_a[sel];
    wire        m_st_rdy  = st_rdy_a[sel];
    wire [1:0]  m_cmd     = cmd_a[sel];
    wire [31:0] m_addr    = addr_a[sel];
    wire [1:0]  m_size    = size_a[sel];
    wire [31:0] m_wdata   = wdata_a[sel];
    wire        m_ld_vld  = ld_vld_a[sel];
    wire [31:0] m_rdata   = rdata_a[sel];
    wire [4:0]  m_tag     = tag_a[sel];
    wire        m_st_done = st_done_a[sel];
    wire        m_busy    = busy_a[sel];

    always #5 clock = ~clock;

    // Memory model for the selected instance: read data appears lat cycles after BUS_LOAD.
    assign Dmem2arb_data = rdbuf[cyc[3:0]];
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (m_cmd == BUS_LOAD) begin
            rdbuf[4'(cyc + lat)] <= mem[m_addr[9:2]];
        end else if (m_cmd == BUS_STORE) begin
            mem[m_addr[9:2]] = m_wdata;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every response pulse; checks idle outputs otherwise.
    exp_t mon_e;
    always @(negedge clock) begin
        if (m_ld_vld || m_st_done) begin
            if (sb.size() == 0) begin
                chk("unexpected_resp", {30'd0, m_ld_vld, m_st_done}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("resp_kind", {31'd0, m_ld_vld}, {31'd0, mon_e.is_load});
                chk("resp_cycle", cyc, mon_e.cyc);
                if (mon_e.is_load) begin
                    chk("resp_data", m_rdata, mon_e.data);
                    chk("resp_tag", {27'd0, m_tag}, {27'd0, mon_e.tag});
                end
            end
        end else begin
            chk("idle_resp_data", m_rdata, 32'd0);
            chk("idle_resp_tag", {27'd0, m_tag}, 32'd0);
        end
        if (m_cmd == BUS_NONE) begin
            chk("idle_bus_addr", m_addr, 32'd0);
            chk("idle_bus_data", m_wdata, 32'd0);
        end
    end

    // Load driver.
    initial begin : ld_drv
        ld_item_t it;
        int waited;
        ld_req_valid = 1'b0; ld_req_addr = '0; ld_req_size = '0;
        ld_req_unsigned = 1'b0; ld_req_tag = '0;
        waited = 0;
        forever begin
            @(posedge clock); #1;
            if (ld_q.size() == 0) begin
                ld_req_valid = 1'b0;
                waited = 0;
            end else begin
                it = ld_q[0];
                ld_req_valid = 1'b1; ld_req_addr = it.addr; ld_req_size = it.size;
                ld_req_unsigned = it.uns; ld_req_tag = it.tag;
                @(negedge clock);
                if (m_ld_rdy) begin
                    chk("ld_bus_cmd", {30'd0, m_cmd}, {30'd0, BUS_LOAD});
                    chk("ld_bus_addr", m_addr, it.addr);
                    chk("ld_bus_size", {30'd0, m_size}, {30'd0, it.size});
                    chk("ld_bus_data", m_wdata, 32'd0);
                    chk("ld_accept_cycle", cyc - base, it.acc);
                    if (!it.squash) sb.push_back('{1'b1, it.data, it.tag, cyc + lat});
                    void'(ld_q.pop_front());
                    waited = 0;
                end else if (++waited > 50) begin
                    chk("ld_accept_timeout", 32'd0, 32'd1);
                    void'(ld_q.pop_front());
                    waited = 0;
                end
            end
        end
    end

    // Store driver.
    initial begin : st_drv
        st_item_t it;
        int waited;
        st_req_valid = 1'b0; st_req_addr = '0; st_req_size = '0; st_req_data = '0;
        waited = 0;
        forever begin
            @(posedge clock); #1;
            if (st_q.size() == 0) begin
                st_req_valid = 1'b0;
                waited = 0;
            end else begin
                it = st_q[0];
                st_req_valid = 1'b1; st_req_addr = it.addr;
                st_req_size = it.size; st_req_data = it.data;
                @(negedge clock);
                if (m_st_rdy) begin
                    chk("st_bus_cmd", {30'd0, m_cmd}, {30'd0, BUS_STORE});
                    chk("st_bus_addr", m_addr, it.addr);
                    chk("st_bus_data", m_wdata, it.data);
                    chk("st_accept_cycle", cyc - base, it.acc);
                    sb.push_back('{1'b0, 32'd0, 5'd0, cyc + lat});
                    void'(st_q.pop_front());
                    waited = 0;
                end else if (++waited > 50) begin
                    chk("st_accept_timeout", 32'd0, 32'd1);
                    void'(st_q.pop_front());
                    waited = 0;
                end
            end
        end
    end

    task automatic do_reset(input int s);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        sel = 2'(s);
        lat = s + 1;
        @(negedge clock);
        chk("rst_busy", {31'd0, m_busy}, 32'd0);
        chk("rst_cmd", {30'd0, m_cmd}, 32'd0);
        chk("rst_ld_resp", {31'd0, m_ld_vld}, 32'd0);
        chk("rst_st_done", {31'd0, m_st_done}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    task automatic start();
        @(negedge clock);
        base = cyc + 1;
    endtask

    task automatic at_cycle(input int c);
        while (cyc != base + c) begin
            @(posedge clock); #1;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            if (ld_q.size() == 0 && st_q.size() == 0 && sb.size() == 0 && !m_busy) break;
            @(negedge clock);
        end
        chk("drain_timeout", {31'd0, (ld_q.size() + st_q.size() + sb.size() != 0) || m_busy},
            32'd0);
        repeat (2) @(negedge clock);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        reset = 1'b1; flush = 1'b0; sel = 2'd1; lat = 2; base = 0;
        n_cmp = 0; n_err = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        for (int i = 0; i < 16; i++) rdbuf[i] = 32'h0;
        mem[32'h100 >> 2] = 32'hDEADBEEF;
        mem[32'h200 >> 2] = 32'h00008080;
        mem[32'h300 >> 2] = 32'h0BADF00D;

        // L=2: single word load
        do_reset(1);
        start();
        ld_q.push_back('{32'h100, SZ_W, 1'b0, 5'd5, 32'hDEADBEEF, 0, 1'b0});
        drain();

        // L=2: extension of 0x00008080, back-to-back in response cycles
        start();
        ld_q.push_back('{32'h200, SZ_B, 1'b0, 5'd1, 32'hFFFFFF80, 0, 1'b0});
        ld_q.push_back('{32'h200, SZ_B, 1'b1, 5'd2, 32'h00000080, 2, 1'b0});
        ld_q.push_back('{32'h200, SZ_H, 1'b0, 5'd3, 32'hFFFF8080, 4, 1'b0});
        ld_q.push_back('{32'h200, SZ_H, 1'b1, 5'd4, 32'h00008080, 6, 1'b0});
        drain();

        // L=2: load/store tie from reset, round-robin starting with the store
        do_reset(1);
        start();
        st_q.push_back('{32'h300, SZ_W, 32'h12345678, 0});
        st_q.push_back('{32'h304, SZ_W, 32'hCAFEF00D, 4});
        ld_q.push_back('{32'h200, SZ_W, 1'b0, 5'd7, 32'h00008080, 2, 1'b0});
        ld_q.push_back('{32'h300, SZ_W, 1'b0, 5'd8, 32'h12345678, 6, 1'b0});
        drain();

        // L=3: flush in cycle 1 of an outstanding load squashes its response
        do_reset(2);
        start();
        ld_q.push_back('{32'h100, SZ_W, 1'b0, 5'd9, 32'h0, 0, 1'b1});
        at_cycle(1); flush = 1'b1;
        at_cycle(2); flush = 1'b0;
        at_cycle(3); @(negedge clock);
        chk("flush_no_resp", {31'd0, m_ld_vld}, 32'd0);
        drain();

        // L=3: a load presented during a flush is not granted
        start();
        ld_q.push_back('{32'h200, SZ_B, 1'b0, 5'd10, 32'hFFFFFF80, 1, 1'b0});
        at_cycle(0); flush = 1'b1;
        @(negedge clock);
        chk("flush_ld_ready", {31'd0, m_ld_rdy}, 32'd0);
        at_cycle(1); flush = 1'b0;
        drain();

        // L=3: an in-flight store survives a flush
        start();
        st_q.push_back('{32'h308, SZ_W, 32'h55AA55AA, 0});
        at_cycle(1); flush = 1'b1;
        at_cycle(2); flush = 1'b0;
        drain();

        // L=3: flush in the response cycle itself suppresses the response
        start();
        ld_q.push_back('{32'h100, SZ_W, 1'b0, 5'd11, 32'h0, 0, 1'b1});
        at_cycle(3); flush = 1'b1;
        @(negedge clock);
        chk("flush_resp_cycle", {31'd0, m_ld_vld}, 32'd0);
        at_cycle(4); flush = 1'b0;
        drain();

        // L=2: reset in cycle 1 of a load drops it
        do_reset(1);
        start();
        ld_q.push_back('{32'h100, SZ_W, 1'b0, 5'd3, 32'h0, 0, 1'b1});
        at_cycle(1); reset = 1'b1;
        at_cycle(2); reset = 1'b0;
        @(negedge clock);
        chk("midrst_busy", {31'd0, m_busy}, 32'd0);
        chk("midrst_cmd", {30'd0, m_cmd}, 32'd0);
        chk("midrst_resp", {31'd0, m_ld_vld}, 32'd0);
        drain();

        // L=1: three loads held valid, one per cycle
        do_reset(0);
        start();
        ld_q.push_back('{32'h100, SZ_W, 1'b0, 5'd12, 32'hDEADBEEF, 0, 1'b0});
        ld_q.push_back('{32'h200, SZ_W, 1'b0, 5'd13, 32'h00008080, 1, 1'b0});
        ld_q.push_back('{32'h300, SZ_W, 1'b0, 5'd14, 32'h12345678, 2, 1'b0});
        drain();

        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
